// File: rtl/arith_serial_unit.sv
// Bit-serial arithmetic unit: one full-adder slice walks WIDTH-bit operands LSB first,
// one bit per clock, with a start/done handshake and carry, overflow and zero flags.
module arith_serial_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic [1:0]       S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] H,
    output logic             Co,
    output logic             V,
    output logic             Z
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [1:0]       func;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             y_bit;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_nxt;

    // Single slice: the B-path bit is selected by the latched function code.
    always_comb begin
        y_bit = 1'b0;
        unique case (func)
            2'b00:   y_bit = 1'b0;
            2'b01:   y_bit = b_sr[0];
            2'b10:   y_bit = ~b_sr[0];
            default: y_bit = 1'b1;
        endcase
        sum_bit   = a_sr[0] ^ y_bit ^ carry;
        carry_nxt = (a_sr[0] & y_bit) | (a_sr[0] & carry) | (y_bit & carry);
        res_nxt              = res_sr >> 1;
        res_nxt[WIDTH-1]     = sum_bit;
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            func   <= 2'b00;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            H      <= '0;
            Co     <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Ci;
                        func  <= S;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StShift: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    // Visible results change only here, so partial sums never leak out.
                    if (last_bit) begin
                        H     <= res_nxt;
                        Co    <= carry_nxt;
                        V     <= carry ^ carry_nxt;
                        Z     <= (res_nxt == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
